unstacker: RTL and testbench



---
 rtl/audio_stream_pkg.sv | 14 +
 rtl/unstacker_if.sv | 27 ++
 rtl/unstacker.sv | 90 +++++++++
 tb/tb_unstacker.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// Shared constants and types for the audio chunk stacker/unstacker pair.
package audio_stream_pkg;

  localparam int SAMPLE_WIDTH      = 16;
  localparam int SAMPLES_PER_CHUNK = 8;
  localparam int CHUNK_WIDTH       = SAMPLE_WIDTH * SAMPLES_PER_CHUNK;
  localparam int IDX_WIDTH         = $clog2(SAMPLES_PER_CHUNK);

  typedef enum logic {EMPTY, DRAIN} unstack_state_t;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [CHUNK_WIDTH-1:0]  chunk_t;

endpackage

// File: rtl/unstacker_if.sv
// Chunk-side and sample-side stream signals of the unstacker.
// slave: the unstacker's view; master: the environment around it.
interface unstacker_if #(
  parameter int SAMPLE_WIDTH      = audio_stream_pkg::SAMPLE_WIDTH,
  parameter int SAMPLES_PER_CHUNK = audio_stream_pkg::SAMPLES_PER_CHUNK
);

  logic                                      audio_chunk_tvalid;
  logic                                      audio_chunk_tready;
  logic [SAMPLE_WIDTH*SAMPLES_PER_CHUNK-1:0] audio_chunk_tdata;
  logic                                      audio_chunk_tlast;
  logic                                      audio_tvalid;
  logic                                      audio_tready;
  logic [SAMPLE_WIDTH-1:0]                   audio_tdata;
  logic                                      audio_tlast;

  modport slave (
    input  audio_chunk_tvalid, audio_chunk_tdata, audio_chunk_tlast, audio_tready,
    output audio_chunk_tready, audio_tvalid, audio_tdata, audio_tlast
  );

  modport master (
    output audio_chunk_tvalid, audio_chunk_tdata, audio_chunk_tlast, audio_tready,
    input  audio_chunk_tready, audio_tvalid, audio_tdata, audio_tlast
  );

endinterface

// File: rtl/unstacker.sv
// Serializes wide memory chunks into audio samples, least-significant first,
// with a zero-bubble handoff between back-to-back chunks.
module unstacker #(
  parameter int SAMPLE_WIDTH      = audio_stream_pkg::SAMPLE_WIDTH,
  parameter int SAMPLES_PER_CHUNK = audio_stream_pkg::SAMPLES_PER_CHUNK
) (
  input logic       clk_in,
  input logic       rst_n_in,
  unstacker_if.slave bus
);

  import audio_stream_pkg::*;

  localparam int CW = SAMPLE_WIDTH * SAMPLES_PER_CHUNK;
  localparam int IW = (SAMPLES_PER_CHUNK > 1) ? $clog2(SAMPLES_PER_CHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES_PER_CHUNK - 1);

  unstack_state_t state, state_next;
  logic [CW-1:0]  hold, hold_next;
  logic [IW-1:0]  idx, idx_next;
  logic           chunk_last, chunk_last_next;

  logic last_idx;
  logic chunk_tready;
  logic accept_in;
  logic accept_out;
  logic tvalid;

  // Handshake decode; chunk ready only reaches back through audio_tready.
  always_comb begin
    last_idx     = (idx == LAST_IDX);
    tvalid       = (state == DRAIN);
    chunk_tready = rst_n_in && ((state == EMPTY) || (last_idx && bus.audio_tready));
    accept_in    = bus.audio_chunk_tvalid && chunk_tready;
    accept_out   = tvalid && bus.audio_tready;
  end

  // Next-state: load on accept, step through samples, hand off or empty after the last.
  always_comb begin
    state_next      = state;
    hold_next       = hold;
    idx_next        = idx;
    chunk_last_next = chunk_last;
    case (state)
      EMPTY: begin
        if (accept_in) begin
          state_next      = DRAIN;
          hold_next       = bus.audio_chunk_tdata;
          idx_next        = '0;
          chunk_last_next = bus.audio_chunk_tlast;
        end
      end
      DRAIN: begin
        if (accept_out) begin
          if (!last_idx) begin
            idx_next = idx + 1'b1;
          end else if (accept_in) begin
            hold_next       = bus.audio_chunk_tdata;
            idx_next        = '0;
            chunk_last_next = bus.audio_chunk_tlast;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= EMPTY;
      hold       <= '0;
      idx        <= '0;
      chunk_last <= 1'b0;
    end else begin
      state      <= state_next;
      hold       <= hold_next;
      idx        <= idx_next;
      chunk_last <= chunk_last_next;
    end
  end

  assign bus.audio_chunk_tready = chunk_tready;
  assign bus.audio_tvalid       = tvalid;
  assign bus.audio_tdata        = tvalid ? hold[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] : '0;
  assign bus.audio_tlast        = chunk_last && last_idx && tvalid;

endmodule

// File: tb/tb_unstacker.sv
// Self-checking bench for unstacker: queue-based sample model plus directed cases.
module tb_unstacker;

  import audio_stream_pkg::*;

  typedef struct {
    chunk_t data;
    logic   last;
  } src_t;

  typedef struct {
    sample_t data;
    logic    last;
  } smp_t;

  logic clk_in;
  logic rst_n_in;

  unstacker_if bus ();

  unstacker #(
    .SAMPLE_WIDTH      (SAMPLE_WIDTH),
    .SAMPLES_PER_CHUNK (SAMPLES_PER_CHUNK)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_fail   = 0;

  src_t src_q[$];
  smp_t exp_q[$];

  logic        manual;
  logic        ready_man;
  logic        rnd_ready;
  int unsigned pct;
  logic        mon_en;

  // Values sampled mid-cycle for the model update at the next rising edge.
  logic   acc_in_s, acc_out_s, rst_s, in_last_s;
  chunk_t in_data_s;

  logic    prev_stall;
  sample_t prev_data;
  logic    prev_last;
  int      sz;
  logic    e_valid, e_ctr;

  assign bus.audio_tready = manual ? ready_man : rnd_ready;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic chunk_t make_chunk(input logic [7:0] tag);
    chunk_t c;
    c = '0;
    for (int k = 0; k < SAMPLES_PER_CHUNK; k++) c[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = {tag, 8'(k)};
    return c;
  endfunction

  // Chunk source: presents the head of src_q, pops it once accepted.
  initial begin
    bus.audio_chunk_tvalid = 1'b0;
    bus.audio_chunk_tdata  = '0;
    bus.audio_chunk_tlast  = 1'b0;
    rnd_ready              = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (acc_in_s && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        bus.audio_chunk_tvalid = 1'b1;
        bus.audio_chunk_tdata  = src_q[0].data;
        bus.audio_chunk_tlast  = src_q[0].last;
      end else begin
        bus.audio_chunk_tvalid = 1'b0;
        bus.audio_chunk_tdata  = '0;
        bus.audio_chunk_tlast  = 1'b0;
      end
      rnd_ready = ($urandom_range(99) < pct);
    end
  end

  // Model: every accepted chunk becomes its samples in order; tlast rides the final one.
  always @(posedge clk_in) begin
    if (!rst_s) begin
      exp_q.delete();
    end else begin
      if (acc_out_s) void'(exp_q.pop_front());
      if (acc_in_s)
        for (int k = 0; k < SAMPLES_PER_CHUNK; k++)
          exp_q.push_back('{in_data_s[k*SAMPLE_WIDTH +: SAMPLE_WIDTH],
                            (k == SAMPLES_PER_CHUNK - 1) && in_last_s});
    end
  end

  // Compare DUT outputs to the model every cycle, mid-cycle.
  always @(negedge clk_in) begin
    sz      = exp_q.size();
    e_valid = (sz > 0);
    e_ctr   = rst_n_in && ((sz == 0) || (sz == 1 && bus.audio_tready));
    if (mon_en) begin
      check("tvalid", bus.audio_tvalid, e_valid);
      check("chunk_tready", bus.audio_chunk_tready, e_ctr);
      if (e_valid) begin
        check("tdata", bus.audio_tdata, exp_q[0].data);
        check("tlast", bus.audio_tlast, exp_q[0].last);
      end
      if (prev_stall) begin
        check("stall_tdata", bus.audio_tdata, prev_data);
        check("stall_tlast", bus.audio_tlast, prev_last);
      end
    end
    prev_stall = bus.audio_tvalid && !bus.audio_tready && rst_n_in;
    prev_data  = bus.audio_tdata;
    prev_last  = bus.audio_tlast;
    acc_in_s   = bus.audio_chunk_tvalid && e_ctr;
    acc_out_s  = e_valid && bus.audio_tready;
    rst_s      = rst_n_in;
    in_data_s  = bus.audio_chunk_tdata;
    in_last_s  = bus.audio_chunk_tlast;
  end

  task automatic wait_sample(input logic [7:0] tag, input logic [7:0] k);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk_in);
      if (bus.audio_tvalid && bus.audio_tdata == {tag, k}) ok = 1'b1;
    end
    check("wait_sample", ok, 1'b1);
  endtask

  task automatic drain_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20000 && !ok; n++) begin
      @(negedge clk_in);
      if (src_q.size() == 0 && exp_q.size() == 0 && !bus.audio_chunk_tvalid) ok = 1'b1;
    end
    check("drain_timeout", ok, 1'b1);
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen, n_tl, tl_pos;
    bit ok;
    chunk_t rc;

    mon_en     = 1'b0;
    manual     = 1'b1;
    ready_man  = 1'b1;
    pct        = 100;
    rst_n_in   = 1'b0;
    acc_in_s   = 1'b0;
    acc_out_s  = 1'b0;
    rst_s      = 1'b0;
    prev_stall = 1'b0;

    // Reset state.
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst_tvalid", bus.audio_tvalid, 1'b0);
    check("rst_tdata", bus.audio_tdata, 16'h0000);
    check("rst_tlast", bus.audio_tlast, 1'b0);
    check("rst_chunk_tready", bus.audio_chunk_tready, 1'b0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    mon_en   = 1'b1;
    @(negedge clk_in);
    check("post_rst_chunk_tready", bus.audio_chunk_tready, 1'b1);

    // Single chunk 0x0007_..._0000 with tlast.
    src_q.push_back('{make_chunk(8'h00), 1'b1});
    wait_sample(8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      check("single_tvalid", bus.audio_tvalid, 1'b1);
      check("single_tdata", bus.audio_tdata, 16'(i));
      check("single_tlast", bus.audio_tlast, i == 7);
      @(negedge clk_in);
    end
    check("single_done_tvalid", bus.audio_tvalid, 1'b0);
    drain_idle();

    // Three back-to-back chunks, always-ready sink.
    for (int c = 1; c <= 3; c++) src_q.push_back('{make_chunk(8'(c)), 1'b0});
    wait_sample(8'h01, 8'h00);
    for (int c = 0; c < 24; c++) begin
      check("b2b_tvalid", bus.audio_tvalid, 1'b1);
      check("b2b_tdata", bus.audio_tdata, {8'(c / 8 + 1), 8'(c % 8)});
      check("b2b_chunk_tready", bus.audio_chunk_tready, (c % 8) == 7);
      @(negedge clk_in);
    end
    drain_idle();

    // Stall at the last sample with the next chunk waiting.
    src_q.push_back('{make_chunk(8'h04), 1'b0});
    src_q.push_back('{make_chunk(8'h05), 1'b0});
    wait_sample(8'h04, 8'h06);
    @(posedge clk_in);
    #1;
    ready_man = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check("stall_chunk_tready", bus.audio_chunk_tready, 1'b0);
      check("stall_hold_tdata", bus.audio_tdata, 16'h0407);
      check("stall_tvalid", bus.audio_tvalid, 1'b1);
    end
    @(posedge clk_in);
    #1;
    ready_man = 1'b1;
    @(negedge clk_in);
    check("handoff_chunk_tready", bus.audio_chunk_tready, 1'b1);
    check("handoff_tdata", bus.audio_tdata, 16'h0407);
    @(negedge clk_in);
    check("next_first_tdata", bus.audio_tdata, 16'h0500);
    check("next_first_tvalid", bus.audio_tvalid, 1'b1);
    drain_idle();

    // tlast=0 chunk then tlast=1 chunk: one tlast, on the 16th sample.
    src_q.push_back('{make_chunk(8'h06), 1'b0});
    src_q.push_back('{make_chunk(8'h07), 1'b1});
    n_seen = 0;
    n_tl   = 0;
    tl_pos = -1;
    for (int n = 0; n < 100 && n_seen < 16; n++) begin
      @(negedge clk_in);
      if (bus.audio_tvalid && bus.audio_tready) begin
        if (bus.audio_tlast) begin
          n_tl++;
          tl_pos = n_seen;
        end
        n_seen++;
      end
    end
    check("tlast_samples", n_seen, 16);
    check("tlast_count", n_tl, 1);
    check("tlast_position", tl_pos, 15);
    drain_idle();

    // Reset mid-chunk at idx 3.
    src_q.push_back('{make_chunk(8'h08), 1'b0});
    wait_sample(8'h08, 8'h02);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("midrst_tvalid", bus.audio_tvalid, 1'b0);
    check("midrst_tdata", bus.audio_tdata, 16'h0000);
    check("midrst_tlast", bus.audio_tlast, 1'b0);
    check("midrst_chunk_tready", bus.audio_chunk_tready, 1'b1);
    src_q.push_back('{make_chunk(8'h09), 1'b0});
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk_in);
      if (bus.audio_tvalid) ok = 1'b1;
    end
    check("midrst_restart_seen", ok, 1'b1);
    check("midrst_restart_tdata", bus.audio_tdata, 16'h0900);
    drain_idle();

    // Random chunks with a 50% ready sink.
    manual = 1'b0;
    pct    = 50;
    for (int c = 0; c < 100; c++) begin
      rc = {$urandom, $urandom, $urandom, $urandom};
      src_q.push_back('{rc, 1'($urandom_range(1))});
    end
    drain_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
